rs_enc_noc_tap: RTL and testbench
=================================

RS_ENC_NOC_TAP -- requirements
Module: rs_enc_noc_tap

Interface
Parameters:
REQ-001 NUM_BYTES_W, default `NOC_DATA_BYTES_W, width base of the per-flit byte count; the output is NUM_BYTES_W+1 bits.
REQ-002 MSG_LEN_LSB, default 0, LSB of the body-flit-count field in a header flit.
REQ-003 MSG_LEN_W, default 8, width of the body-flit-count field.
REQ-004 PAYLOAD_BYTES_LSB, default 16, LSB of the payload-byte-count field in a header flit.
REQ-005 PAYLOAD_BYTES_W, default 16, width of the payload-byte-count field.
REQ-006 MAX_REQ_BYTES, default 9000, largest legal payload byte count; used only under REQ-032.
Ports:
REQ-007 clk  in  1  sole clock; all state on rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 noc_tap_val  in  1  observed valid of the RS encoder's outgoing NoC stream.
REQ-010 noc_tap_data  in  `NOC_DATA_WIDTH  observed flit.
REQ-011 noc_tap_rdy  in  1  observed ready of that stream; the tap never drives the stream.
REQ-012 rs_enc_incr_bytes_sent  out  1  one-cycle pulse: bytes delivered by the current flit.
REQ-013 rs_enc_num_bytes_sent  out  NUM_BYTES_W+1  byte count qualified by incr_bytes_sent, 1..`NOC_DATA_BYTES.
REQ-014 rs_enc_incr_reqs_done  out  1  one-cycle pulse: one request fully transmitted.

Function
REQ-015 A flit is accepted only in a cycle where noc_tap_val and noc_tap_rdy are both 1; no other cycle changes state.
REQ-016 The FSM SHALL have two states, HDR and BODY; reset state is HDR.
REQ-017 In HDR, an accepted flit is a header: flits_rem loads MSG_LEN and bytes_rem loads PAYLOAD_BYTES.
REQ-018 In HDR, a header with MSG_LEN != 0 moves the FSM to BODY.
REQ-019 In HDR, a header with MSG_LEN == 0 leaves the FSM in HDR and pulses rs_enc_incr_reqs_done.
REQ-020 In BODY, each accepted flit computes n = min(bytes_rem, `NOC_DATA_BYTES).
REQ-021 In BODY, bytes_rem decrements by n, saturating at 0.
REQ-022 In BODY, flits_rem decrements by 1.
REQ-023 In BODY, incr_bytes_sent pulses with num_bytes_sent = n when n > 0; when n == 0 (padding flit), incr_bytes_sent stays 0.
REQ-024 In BODY, the flit accepted with flits_rem == 1 is the last flit; it pulses incr_reqs_done and returns the FSM to HDR.
REQ-025 All outputs are registered, one cycle after the accepting edge; a last flit pulses incr_bytes_sent and incr_reqs_done in the same cycle.
REQ-026 Back-to-back requests are supported: a header accepted in the cycle after a last flit is parsed normally, with no bubble.
REQ-027 num_bytes_sent holds 0 whenever incr_bytes_sent is 0.
REQ-028 Arithmetic is unsigned; bytes_rem is PAYLOAD_BYTES_W bits and flits_rem is MSG_LEN_W bits.
REQ-029 PAYLOAD_BYTES larger than MSG_LEN*`NOC_DATA_BYTES is not an error: excess bytes are discarded at request end.

Reset
REQ-030 While rst = 1: FSM = HDR; flits_rem, bytes_rem = 0; all outputs = 0; a reset during BODY abandons the partial request and sends no done pulse.
REQ-031 In the first cycle after rst deasserts, an accepted flit is treated as a header.

Configuration
REQ-032 With macro RS_ENC_TAP_LEN_CHECK_EN defined, the block adds port rs_enc_tap_err (out, 1), a sticky error flag cleared only by rst.
REQ-033 With RS_ENC_TAP_LEN_CHECK_EN defined, a header whose PAYLOAD_BYTES > MAX_REQ_BYTES sets rs_enc_tap_err one cycle after acceptance.
REQ-034 With RS_ENC_TAP_LEN_CHECK_EN defined, that request is still framed (flits counted, FSM returns to HDR) but generates no incr_bytes_sent or incr_reqs_done pulses.
REQ-035 Without RS_ENC_TAP_LEN_CHECK_EN, the port does not exist, MAX_REQ_BYTES is unused and every request is counted.

Verification
REQ-036 `NOC_DATA_BYTES = 64; header MSG_LEN = 3, PAYLOAD = 150; 3 body flits back-to-back -> byte pulses 64, 64, 22; reqs_done with the third.
REQ-037 Header MSG_LEN = 0 -> exactly one reqs_done pulse, no byte pulse, FSM stays in HDR.
REQ-038 Request MSG_LEN = 2, PAYLOAD = 64 -> pulses 64 then none; reqs_done on the second flit.
REQ-039 val = 1 with rdy = 0 for 5 cycles mid-body -> no pulses, counters unchanged; the count resumes on rdy.
REQ-040 rst asserted after the first of 3 body flits, then a new MSG_LEN = 1, PAYLOAD = 10 request -> a single 10 pulse plus done; no done for the aborted request.
REQ-041 With RS_ENC_TAP_LEN_CHECK_EN, PAYLOAD = 9001 -> rs_enc_tap_err = 1 and no pulses; the next legal request counts normally and err stays 1.

Source files
------------

// File: rtl/rs_enc_noc_tap.sv
// rs_enc_noc_tap: passive tap on the RS encoder NoC output that counts delivered payload bytes and completed requests.
// Optional build macro RS_ENC_TAP_LEN_CHECK_EN adds a sticky oversize-payload error flag.
`default_nettype none

`ifndef NOC_DATA_BYTES
`define NOC_DATA_BYTES 64
`endif
`ifndef NOC_DATA_BYTES_W
`define NOC_DATA_BYTES_W 6
`endif
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 512
`endif

module rs_enc_noc_tap #(
    parameter int NUM_BYTES_W       = `NOC_DATA_BYTES_W,
    parameter int MSG_LEN_LSB       = 0,
    parameter int MSG_LEN_W         = 8,
    parameter int PAYLOAD_BYTES_LSB = 16,
    parameter int PAYLOAD_BYTES_W   = 16,
    parameter int MAX_REQ_BYTES     = 9000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       noc_tap_val,
    input  logic [`NOC_DATA_WIDTH-1:0] noc_tap_data,
    input  logic                       noc_tap_rdy,
    output logic                       rs_enc_incr_bytes_sent,
    output logic [NUM_BYTES_W:0]       rs_enc_num_bytes_sent,
    output logic                       rs_enc_incr_reqs_done
`ifdef RS_ENC_TAP_LEN_CHECK_EN
    ,
    output logic                       rs_enc_tap_err
`endif
);

    localparam logic [PAYLOAD_BYTES_W-1:0] FLIT_BYTES = PAYLOAD_BYTES_W'(`NOC_DATA_BYTES);

    typedef enum logic [0:0] {
        S_HDR  = 1'b0,
        S_BODY = 1'b1
    } state_t;

    state_t                     state_q;
    logic [MSG_LEN_W-1:0]       flits_rem_q;
    logic [PAYLOAD_BYTES_W-1:0] bytes_rem_q;
    logic                       req_bad_q;
    logic                       incr_bytes_q;
    logic [NUM_BYTES_W:0]       num_bytes_q;
    logic                       reqs_done_q;

    logic                       w_fire;
    logic [MSG_LEN_W-1:0]       w_hdr_len;
    logic [PAYLOAD_BYTES_W-1:0] w_hdr_bytes;
    logic [PAYLOAD_BYTES_W-1:0] w_n;
    logic                       w_hdr_bad;
    logic                       w_unused;

    assign w_fire      = noc_tap_val & noc_tap_rdy;
    assign w_hdr_len   = noc_tap_data[MSG_LEN_LSB +: MSG_LEN_W];
    assign w_hdr_bytes = noc_tap_data[PAYLOAD_BYTES_LSB +: PAYLOAD_BYTES_W];
    // n never exceeds bytes_rem, so the subtraction below saturates at zero by construction.
    assign w_n         = (bytes_rem_q < FLIT_BYTES) ? bytes_rem_q : FLIT_BYTES;

`ifdef RS_ENC_TAP_LEN_CHECK_EN
    logic err_q;
    assign w_hdr_bad      = (32'(w_hdr_bytes) > 32'(MAX_REQ_BYTES));
    assign rs_enc_tap_err = err_q;
    assign w_unused       = ^noc_tap_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (w_fire && (state_q == S_HDR) && w_hdr_bad) begin
            err_q <= 1'b1;
        end
    end
`else
    assign w_hdr_bad = 1'b0;
    assign w_unused  = ^{noc_tap_data, 32'(MAX_REQ_BYTES)};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_HDR;
            flits_rem_q  <= '0;
            bytes_rem_q  <= '0;
            req_bad_q    <= 1'b0;
            incr_bytes_q <= 1'b0;
            num_bytes_q  <= '0;
            reqs_done_q  <= 1'b0;
        end else begin
            incr_bytes_q <= 1'b0;
            num_bytes_q  <= '0;
            reqs_done_q  <= 1'b0;
            if (w_fire) begin
                case (state_q)
                    S_HDR: begin
                        flits_rem_q <= w_hdr_len;
                        bytes_rem_q <= w_hdr_bytes;
                        req_bad_q   <= w_hdr_bad;
                        if (w_hdr_len != '0) begin
                            state_q <= S_BODY;
                        end else begin
                            reqs_done_q <= ~w_hdr_bad;
                        end
                    end
                    S_BODY: begin
                        bytes_rem_q <= bytes_rem_q - w_n;
                        flits_rem_q <= flits_rem_q - 1'b1;
                        if ((w_n != '0) && !req_bad_q) begin
                            incr_bytes_q <= 1'b1;
                            num_bytes_q  <= (NUM_BYTES_W+1)'(w_n);
                        end
                        if (flits_rem_q == MSG_LEN_W'(1)) begin
                            reqs_done_q <= ~req_bad_q;
                            state_q     <= S_HDR;
                        end
                    end
                    default: state_q <= S_HDR;
                endcase
            end
        end
    end

    assign rs_enc_incr_bytes_sent = incr_bytes_q;
    assign rs_enc_num_bytes_sent  = num_bytes_q;
    assign rs_enc_incr_reqs_done  = reqs_done_q;

endmodule

`default_nettype wire

// File: tb/tb_rs_enc_noc_tap.sv
// tb_rs_enc_noc_tap: directed stimulus, request-level reference model and literal pulse-sequence checks.
`default_nettype none

`ifndef NOC_DATA_BYTES
`define NOC_DATA_BYTES 64
`endif
`ifndef NOC_DATA_BYTES_W
`define NOC_DATA_BYTES_W 6
`endif
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 512
`endif

module tb_rs_enc_noc_tap;

`ifdef RS_ENC_TAP_LEN_CHECK_EN
    localparam bit LENCHK = 1'b1;
`else
    localparam bit LENCHK = 1'b0;
`endif

    logic                       clk;
    logic                       rst;
    logic                       val;
    logic                       rdy;
    logic [`NOC_DATA_WIDTH-1:0] data;
    logic                       incr_bytes;
    logic [`NOC_DATA_BYTES_W:0] num_bytes;
    logic                       reqs_done;
    logic                       tap_err;

    int checks = 0;
    int errors = 0;

    rs_enc_noc_tap dut (
        .clk                    (clk),
        .rst                    (rst),
        .noc_tap_val            (val),
        .noc_tap_data           (data),
        .noc_tap_rdy            (rdy),
        .rs_enc_incr_bytes_sent (incr_bytes),
        .rs_enc_num_bytes_sent  (num_bytes),
        .rs_enc_incr_reqs_done  (reqs_done)
`ifdef RS_ENC_TAP_LEN_CHECK_EN
        ,
        .rs_enc_tap_err         (tap_err)
`endif
    );
`ifndef RS_ENC_TAP_LEN_CHECK_EN
    assign tap_err = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: a header expands into a per-flit list of byte counts.
    int  q_n[$];
    bit  q_last[$];
    bit  q_bad[$];
    bit  started = 0;
    bit  e_incr, e_done, e_err;
    int  e_num;

    always @(posedge clk) begin
        int len, pay, n;
        bit bad, l, b;
        started = 1;
        e_incr = 0; e_num = 0; e_done = 0;
        if (rst) begin
            q_n.delete(); q_last.delete(); q_bad.delete();
            e_err = 0;
        end else if (val && rdy) begin
            if (q_n.size() == 0) begin
                len = int'(data[7:0]);
                pay = int'(data[31:16]);
                bad = LENCHK && (pay > 9000);
                if (bad) e_err = 1;
                if (len == 0) e_done = !bad;
                for (int i = 0; i < len; i++) begin
                    n = (pay < `NOC_DATA_BYTES) ? pay : `NOC_DATA_BYTES;
                    pay -= n;
                    q_n.push_back(n);
                    q_last.push_back(i == len - 1);
                    q_bad.push_back(bad);
                end
            end else begin
                n = q_n.pop_front();
                l = q_last.pop_front();
                b = q_bad.pop_front();
                if (!b && n > 0) begin
                    e_incr = 1;
                    e_num  = n;
                end
                e_done = l && !b;
            end
        end
    end

    int seen[$];
    int done_cnt = 0;

    always @(negedge clk) begin
        if (started) begin
            chk("incr_bytes_sent", int'(incr_bytes), int'(e_incr));
            chk("num_bytes_sent", int'(num_bytes), e_num);
            chk("incr_reqs_done", int'(reqs_done), int'(e_done));
            if (LENCHK) chk("tap_err", int'(tap_err), int'(e_err));
            if (incr_bytes) seen.push_back(int'(num_bytes));
            if (reqs_done) done_cnt++;
        end
    end

    function automatic logic [`NOC_DATA_WIDTH-1:0] hdr(input int len, input int pay);
        logic [`NOC_DATA_WIDTH-1:0] d;
        for (int i = 0; i < `NOC_DATA_WIDTH / 32; i++) d[i*32 +: 32] = $urandom;
        d[7:0]   = len[7:0];
        d[31:16] = pay[15:0];
        return d;
    endfunction

    function automatic logic [`NOC_DATA_WIDTH-1:0] body();
        logic [`NOC_DATA_WIDTH-1:0] d;
        for (int i = 0; i < `NOC_DATA_WIDTH / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic drive(input logic v, input logic r, input logic [`NOC_DATA_WIDTH-1:0] d);
        val  = v;
        rdy  = r;
        data = d;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, body());
    endtask

    task automatic start_scn();
        seen.delete();
        done_cnt = 0;
    endtask

    task automatic expect_seq(input string name, input int exp[$], input int exp_done);
        chk({name, " pulse count"}, seen.size(), exp.size());
        for (int i = 0; i < exp.size() && i < seen.size(); i++)
            chk({name, " pulse value"}, seen[i], exp[i]);
        chk({name, " done count"}, done_cnt, exp_done);
    endtask

    initial begin
        rst = 1'b1; val = 1'b0; rdy = 1'b1; data = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset incr_bytes", int'(incr_bytes), 0);
        chk("reset num_bytes", int'(num_bytes), 0);
        chk("reset reqs_done", int'(reqs_done), 0);
        rst = 1'b0;

        // 3 flits, 150 bytes
        start_scn();
        drive(1, 1, hdr(3, 150));
        drive(1, 1, body()); drive(1, 1, body()); drive(1, 1, body());
        idle(2);
        expect_seq("len3_150", '{64, 64, 22}, 1);

        // zero-length request, then a header right behind it
        start_scn();
        drive(1, 1, hdr(0, 50));
        drive(1, 1, hdr(1, 5));
        drive(1, 1, body());
        idle(2);
        expect_seq("len0_then_len1", '{5}, 2);

        // padding flit
        start_scn();
        drive(1, 1, hdr(2, 64));
        drive(1, 1, body()); drive(1, 1, body());
        idle(2);
        expect_seq("len2_64", '{64}, 1);

        // backpressure mid-body
        start_scn();
        drive(1, 1, hdr(3, 150));
        drive(1, 1, body());
        for (int i = 0; i < 5; i++) drive(1, 0, body());
        chk("stall pulses", seen.size(), 1);
        drive(1, 1, body()); drive(1, 1, body());
        idle(2);
        expect_seq("stall", '{64, 64, 22}, 1);

        // reset abandons a partial request
        start_scn();
        drive(1, 1, hdr(3, 150));
        drive(1, 1, body());
        rst = 1'b1;
        drive(0, 1, body());
        rst = 1'b0;
        drive(1, 1, hdr(1, 10));
        drive(1, 1, body());
        idle(2);
        expect_seq("abort", '{64, 10}, 1);

        // back-to-back requests, excess payload discarded
        start_scn();
        drive(1, 1, hdr(1, 100));
        drive(1, 1, body());
        drive(1, 1, hdr(2, 70));
        drive(1, 1, body()); drive(1, 1, body());
        idle(2);
        expect_seq("b2b", '{64, 64, 6}, 2);

`ifdef RS_ENC_TAP_LEN_CHECK_EN
        start_scn();
        drive(1, 1, hdr(2, 9001));
        drive(1, 1, body()); drive(1, 1, body());
        idle(2);
        expect_seq("oversize", '{}, 0);
        chk("err set", int'(tap_err), 1);
        start_scn();
        drive(1, 1, hdr(1, 10));
        drive(1, 1, body());
        idle(2);
        expect_seq("after_err", '{10}, 1);
        chk("err sticky", int'(tap_err), 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
